// File: rtl/game_tick_scheduler.sv
// rtl/game_tick_scheduler.sv - PONG speed scheduler: prescaled ball/paddle/button enable strobes with level loading.
// Optional GTS_SPEED_RAMP_EN: ball_div shrinks by 1 every RAMP_STEP ball ticks in RUN, down to MIN_DIV.
module game_tick_scheduler #(
  parameter int PRESCALE  = 1024,
  parameter int MIN_DIV   = 16,
  parameter int RAMP_STEP = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] level,
  input  logic       level_req,
  output logic       level_ack,
  input  logic       run,
  output logic       ball_tick,
  output logic       paddle_tick,
  output logic       button_tick,
  output logic [7:0] ball_div,
  output logic [1:0] state
);

  localparam int PW = $clog2(PRESCALE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LOAD  = 2'd3
  } state_t;

  state_t         st, st_nxt, saved_st;
  logic [PW-1:0]  pcnt;
  logic           base;
  logic [7:0]     ball_cnt, pad_cnt, paddle_div;
  logic           pend;
  logic [3:0]     pend_lvl;

  // {ball_div, paddle_div} per level; unlisted levels fall back to level 1
  function automatic logic [15:0] level_divs(input logic [3:0] lvl);
    case (lvl)
      4'd2:    level_divs = {8'd64, 8'd32};
      4'd3:    level_divs = {8'd60, 8'd30};
      4'd4:    level_divs = {8'd50, 8'd25};
      4'd5:    level_divs = {8'd40, 8'd20};
      default: level_divs = {8'd128, 8'd128};
    endcase
  endfunction

  assign base      = (pcnt == PW'(PRESCALE - 1));
  assign level_ack = (st == S_LOAD);
  assign state     = st;

`ifdef GTS_SPEED_RAMP_EN
  logic [7:0] ramp_cnt;
`else
  logic unused_ramp_cfg;
  assign unused_ramp_cfg = ^{8'(MIN_DIV), 8'(RAMP_STEP)};
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) st <= S_IDLE;
    else          st <= st_nxt;
  end

  // In RUN a pending level waits for a ball period boundary so the ball never jumps mid-period
  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE:  if (pend || level_req) st_nxt = S_LOAD;
               else if (run)          st_nxt = S_RUN;
      S_RUN:   if (ball_tick && pend) st_nxt = S_LOAD;
               else if (!run)         st_nxt = S_PAUSE;
      S_PAUSE: if (pend || level_req) st_nxt = S_LOAD;
               else if (run)          st_nxt = S_RUN;
      S_LOAD:  if (saved_st == S_IDLE) st_nxt = S_IDLE;
               else                    st_nxt = run ? S_RUN : S_PAUSE;
      default: st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pcnt        <= '0;
      button_tick <= 1'b0;
      ball_tick   <= 1'b0;
      paddle_tick <= 1'b0;
      ball_cnt    <= 8'd0;
      pad_cnt     <= 8'd0;
      ball_div    <= 8'd128;
      paddle_div  <= 8'd128;
      pend        <= 1'b0;
      pend_lvl    <= 4'd0;
      saved_st    <= S_IDLE;
`ifdef GTS_SPEED_RAMP_EN
      ramp_cnt    <= 8'd0;
`endif
    end else begin
      pcnt        <= base ? '0 : pcnt + PW'(1);
      button_tick <= base;
      ball_tick   <= 1'b0;
      paddle_tick <= 1'b0;

      if (st == S_LOAD) begin
        {ball_div, paddle_div} <= level_divs(pend_lvl);
        ball_cnt <= 8'd0;
        pad_cnt  <= 8'd0;
        pend     <= 1'b0;
`ifdef GTS_SPEED_RAMP_EN
        ramp_cnt <= 8'd0;
`endif
      end else if (st == S_RUN && base) begin
        if (ball_cnt == ball_div - 8'd1) begin
          ball_cnt  <= 8'd0;
          ball_tick <= 1'b1;
`ifdef GTS_SPEED_RAMP_EN
          if (ramp_cnt == 8'(RAMP_STEP - 1)) begin
            ramp_cnt <= 8'd0;
            if (ball_div > 8'(MIN_DIV)) ball_div <= ball_div - 8'd1;
          end else begin
            ramp_cnt <= ramp_cnt + 8'd1;
          end
`endif
        end else begin
          ball_cnt <= ball_cnt + 8'd1;
        end
        if (pad_cnt == paddle_div - 8'd1) begin
          pad_cnt     <= 8'd0;
          paddle_tick <= 1'b1;
        end else begin
          pad_cnt <= pad_cnt + 8'd1;
        end
      end

      // A request in the LOAD cycle survives the clear and is applied next time
      if (level_req) begin
        pend     <= 1'b1;
        pend_lvl <= level;
      end
      if (st_nxt == S_LOAD && st != S_LOAD) saved_st <= st;
    end
  end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb/tb_game_tick_scheduler.sv - scenario tests plus randomized run against a behavioural model.
module tb_game_tick_scheduler;
  localparam int P = 4;
  localparam int MIN_DIV = 16;
  localparam int RAMP_STEP = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] level = 4'd0;
  logic       level_req = 1'b0;
  logic       level_ack;
  logic       run = 1'b0;
  logic       ball_tick, paddle_tick, button_tick;
  logic [7:0] ball_div;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  game_tick_scheduler #(.PRESCALE(P), .MIN_DIV(MIN_DIV), .RAMP_STEP(RAMP_STEP)) dut (
    .clk(clk), .reset_n(reset_n), .level(level), .level_req(level_req),
    .level_ack(level_ack), .run(run), .ball_tick(ball_tick),
    .paddle_tick(paddle_tick), .button_tick(button_tick),
    .ball_div(ball_div), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; run = 1'b0; level_req = 1'b0; level = 4'd0;
    step(); step();
    reset_n = 1'b1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: sig = ball_tick;
      1: sig = paddle_tick;
      2: sig = button_tick;
      default: sig = level_ack;
    endcase
  endfunction

  // Cycles until the selected strobe next shows, or -1 when the budget expires
  task automatic wait_sig(input int which, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (sig(which)) begin n = i; break; end
    end
  endtask

  function automatic int ball_of(input int l);
    case (l) 2: return 64; 3: return 60; 4: return 50; 5: return 40; default: return 128; endcase
  endfunction
  function automatic int pad_of(input int l);
    case (l) 2: return 32; 3: return 30; 4: return 25; 5: return 20; default: return 128; endcase
  endfunction

  task automatic test_reset();
    run = 1'b1; level = 4'd5; level_req = 1'b1; reset_n = 1'b0;
    step();
    checks++; if (ball_tick !== 1'b0)   begin errors++; $display("FAIL reset_ball_tick got=%b exp=0", ball_tick); end
    checks++; if (paddle_tick !== 1'b0) begin errors++; $display("FAIL reset_paddle_tick got=%b exp=0", paddle_tick); end
    checks++; if (button_tick !== 1'b0) begin errors++; $display("FAIL reset_button_tick got=%b exp=0", button_tick); end
    checks++; if (level_ack !== 1'b0)   begin errors++; $display("FAIL reset_level_ack got=%b exp=0", level_ack); end
    checks++; if (ball_div !== 8'd128)  begin errors++; $display("FAIL reset_ball_div got=%0d exp=128", ball_div); end
    checks++; if (state !== 2'd0)       begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    level_req = 1'b0;
  endtask

  task automatic test_periods();
    int n;
    do_reset();
    run = 1'b1;
    step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL run_state got=%0d exp=1", state); end
    wait_sig(0, 2000, n);
    wait_sig(0, 600, n);
    checks++; if (n !== 512) begin errors++; $display("FAIL l1_ball_period got=%0d exp=512", n); end
    wait_sig(1, 600, n);
    checks++; if (n !== 512) begin errors++; $display("FAIL l1_paddle_period got=%0d exp=512", n); end
    wait_sig(2, 10, n);
    checks++; if (n !== P) begin errors++; $display("FAIL button_period got=%0d exp=%0d", n, P); end
  endtask

  task automatic test_level_idle();
    int n;
    do_reset();
    level = 4'd2; level_req = 1'b1;
    step();
    level_req = 1'b0;
    checks++; if (level_ack !== 1'b1) begin errors++; $display("FAIL idle_ack got=%b exp=1", level_ack); end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL idle_load_state got=%0d exp=3", state); end
    step();
    checks++; if (level_ack !== 1'b0) begin errors++; $display("FAIL idle_ack_pulse got=%b exp=0", level_ack); end
    checks++; if (ball_div !== 8'd64) begin errors++; $display("FAIL l2_ball_div got=%0d exp=64", ball_div); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_return got=%0d exp=0", state); end
    run = 1'b1;
    wait_sig(0, 2000, n);
    wait_sig(0, 400, n);
    checks++; if (n !== 256) begin errors++; $display("FAIL l2_ball_period got=%0d exp=256", n); end
    wait_sig(1, 200, n);
    checks++; if (n !== 128) begin errors++; $display("FAIL l2_paddle_period got=%0d exp=128", n); end
  endtask

  task automatic test_level_run();
    int n;
    int acks = 0;
    bit seen = 0;
    do_reset();
    run = 1'b1;
    wait_sig(0, 2000, n);
    repeat (100) step();
    level = 4'd5; level_req = 1'b1;
    step();
    level_req = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (level_ack) acks++;
      if (ball_tick) begin seen = 1; break; end
      step();
    end
    checks++; if (acks !== 0 || !seen) begin errors++; $display("FAIL run_early_ack acks=%0d tick_seen=%0d exp acks=0 tick_seen=1", acks, seen); end
    step();
    checks++; if (level_ack !== 1'b1) begin errors++; $display("FAIL run_ack_after_tick got=%b exp=1", level_ack); end
    step();
    checks++; if (ball_div !== 8'd40) begin errors++; $display("FAIL l5_ball_div got=%0d exp=40", ball_div); end
    wait_sig(0, 400, n);
    wait_sig(0, 400, n);
    checks++; if (n !== 160) begin errors++; $display("FAIL l5_ball_period got=%0d exp=160", n); end
    wait_sig(1, 200, n);
    checks++; if (n !== 80) begin errors++; $display("FAIL l5_paddle_period got=%0d exp=80", n); end
  endtask

  task automatic test_pause();
    int n;
    int moves = 0, btns = 0;
    bit seen = 0;
    do_reset();
    run = 1'b1;
    wait_sig(0, 2000, n);
    repeat (100) wait_sig(2, 10, n);
    run = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (ball_tick || paddle_tick) moves++;
      if (button_tick) btns++;
    end
    checks++; if (moves !== 0) begin errors++; $display("FAIL pause_moves got=%0d exp=0", moves); end
    checks++; if (btns !== 250) begin errors++; $display("FAIL pause_buttons got=%0d exp=250", btns); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL pause_state got=%0d exp=2", state); end
    run = 1'b1;
    btns = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (button_tick) btns++;
      if (ball_tick) begin seen = 1; break; end
    end
    checks++; if (btns !== 28 || !seen) begin errors++; $display("FAIL resume_phase got=%0d seen=%0d exp=28 seen=1", btns, seen); end
  endtask

  task automatic test_level_default();
    int n;
    do_reset();
    level = 4'd3; level_req = 1'b1; step(); level_req = 1'b0; step();
    checks++; if (ball_div !== 8'd60) begin errors++; $display("FAIL l3_ball_div got=%0d exp=60", ball_div); end
    level = 4'd9; level_req = 1'b1; step(); level_req = 1'b0; step();
    checks++; if (ball_div !== 8'd128) begin errors++; $display("FAIL l9_ball_div got=%0d exp=128", ball_div); end
    level = 4'd3; level_req = 1'b1; step(); level_req = 1'b0; step();
    level = 4'd0; level_req = 1'b1; step(); level_req = 1'b0; step();
    checks++; if (ball_div !== 8'd128) begin errors++; $display("FAIL l0_ball_div got=%0d exp=128", ball_div); end
    run = 1'b1;
    wait_sig(0, 2000, n);
    wait_sig(1, 600, n);
    checks++; if (n !== 512) begin errors++; $display("FAIL l0_paddle_period got=%0d exp=512", n); end
    level = 4'd4; level_req = 1'b1; step();
    level = 4'd2; step();
    level_req = 1'b0;
    wait_sig(3, 1200, n);
    step();
    checks++; if (n < 0 || ball_div !== 8'd64) begin errors++; $display("FAIL last_req_wins got=%0d ack_wait=%0d exp=64", ball_div, n); end
  endtask

  task automatic test_reset_midrun();
    int n;
    int acks = 0;
    do_reset();
    run = 1'b1;
    wait_sig(0, 2000, n);
    repeat (50) step();
    level = 4'd5; level_req = 1'b1; step(); level_req = 1'b0;
    reset_n = 1'b0;
    step();
    checks++; if ({ball_tick, paddle_tick, button_tick, level_ack} !== 4'b0) begin errors++; $display("FAIL midrun_reset_strobes got=%b exp=0000", {ball_tick, paddle_tick, button_tick, level_ack}); end
    checks++; if (ball_div !== 8'd128 || state !== 2'd0) begin errors++; $display("FAIL midrun_reset_regs div=%0d state=%0d exp 128/0", ball_div, state); end
    reset_n = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      step();
      if (level_ack) acks++;
    end
    checks++; if (acks !== 0 || ball_div !== 8'd128) begin errors++; $display("FAIL midrun_pend_aborted acks=%0d div=%0d exp 0/128", acks, ball_div); end
  endtask

  // Behavioural model: elapsed-base counts per channel, state as plain ints
  int m_st, m_saved, m_k, m_bel, m_pel, m_ramp, m_bdiv, m_pdiv, m_plvl;
  bit m_pend, m_bt, m_pt, m_btn;

  task automatic model_edge(input bit rn, input bit r, input int lv, input bit rq);
    int nst;
    bit is_base, nbt, npt;
    if (!rn) begin
      m_st = 0; m_saved = 0; m_k = 0; m_bel = 0; m_pel = 0; m_ramp = 0;
      m_bdiv = 128; m_pdiv = 128; m_pend = 0; m_plvl = 0; m_bt = 0; m_pt = 0; m_btn = 0;
      return;
    end
    is_base = ((m_k % P) == P - 1);
    case (m_st)
      0: nst = (m_pend || rq) ? 3 : (r ? 1 : 0);
      1: nst = (m_bt && m_pend) ? 3 : (!r ? 2 : 1);
      2: nst = (m_pend || rq) ? 3 : (r ? 1 : 2);
      default: nst = (m_saved == 0) ? 0 : (r ? 1 : 2);
    endcase
    if (nst == 3 && m_st != 3) m_saved = m_st;
    nbt = 0; npt = 0;
    if (m_st == 3) begin
      m_bdiv = ball_of(m_plvl); m_pdiv = pad_of(m_plvl);
      m_bel = 0; m_pel = 0; m_ramp = 0; m_pend = 0;
    end else if (m_st == 1 && is_base) begin
      m_bel++;
      if (m_bel == m_bdiv) begin
        m_bel = 0; nbt = 1;
`ifdef GTS_SPEED_RAMP_EN
        m_ramp++;
        if (m_ramp == RAMP_STEP) begin
          m_ramp = 0;
          if (m_bdiv > MIN_DIV) m_bdiv--;
        end
`endif
      end
      m_pel++;
      if (m_pel == m_pdiv) begin m_pel = 0; npt = 1; end
    end
    m_btn = is_base; m_bt = nbt; m_pt = npt;
    if (rq) begin m_pend = 1; m_plvl = lv; end
    m_st = nst;
    m_k++;
  endtask

  task automatic test_random();
    reset_n = 1'b0; run = 1'b0; level_req = 1'b0;
    step();
    model_edge(1'b0, 1'b0, 0, 1'b0);
    for (int c = 0; c < 12000; c++) begin
      reset_n   = ($urandom_range(0, 4999) != 0);
      if ($urandom_range(0, 299) == 0) run = ~run;
      if (c < 20) run = 1'b1;
      level_req = ($urandom_range(0, 199) == 0);
      level     = 4'($urandom_range(0, 15));
      step();
      model_edge(reset_n, run, int'(level), level_req);
      checks++; if (ball_tick !== m_bt)   begin errors++; $display("FAIL rand_ball_tick c=%0d got=%b exp=%b", c, ball_tick, m_bt); end
      checks++; if (paddle_tick !== m_pt) begin errors++; $display("FAIL rand_paddle_tick c=%0d got=%b exp=%b", c, paddle_tick, m_pt); end
      checks++; if (button_tick !== m_btn) begin errors++; $display("FAIL rand_button_tick c=%0d got=%b exp=%b", c, button_tick, m_btn); end
      checks++; if (level_ack !== (m_st == 3)) begin errors++; $display("FAIL rand_level_ack c=%0d got=%b exp=%b", c, level_ack, (m_st == 3)); end
      checks++; if (ball_div !== 8'(m_bdiv)) begin errors++; $display("FAIL rand_ball_div c=%0d got=%0d exp=%0d", c, ball_div, m_bdiv); end
      checks++; if (state !== 2'(m_st)) begin errors++; $display("FAIL rand_state c=%0d got=%0d exp=%0d", c, state, m_st); end
    end
  endtask

  initial begin
    test_reset();
    test_periods();
    test_level_idle();
    test_level_run();
    test_pause();
    test_level_default();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
